// File: rtl/axis_pkg.sv
// Shared AXI-stream types for the ingress/egress shims and their register slices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   AXIS_DATA_W / AXIS_USER_W  default beat widths used by axis_beat_t
//   ingress_state_e            frame-length policing state of axis_ingress
//   axis_beat_t                one stream beat {data, last, user}
package axis_pkg;

    localparam int AXIS_DATA_W = 64;
    localparam int AXIS_USER_W = 1;

    typedef enum logic [0:0] {
        ST_PASS    = 1'b0,
        ST_DISCARD = 1'b1
    } ingress_state_e;

    typedef struct packed {
        logic [AXIS_DATA_W-1:0] data;
        logic                   last;
        logic [AXIS_USER_W-1:0] user;
    } axis_beat_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry register slice: output register plus one skid register, all outputs from flops.
// Latency: a beat accepted at edge N is presented downstream after edge N (one cycle).
// Backpressure: up_rdy is a flop equal to "skid empty"; it drops the cycle after the skid fills.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   up_vld/up_rdy     upstream handshake, up_dat the offered beat
//   dn_vld/dn_rdy     downstream handshake, dn_dat the registered beat (zero while dn_vld=0)
module axis_skid_buffer
    import axis_pkg::*;
#(
    parameter type beat_t = axis_beat_t
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  up_vld,
    output logic  up_rdy,
    input  beat_t up_dat,
    output logic  dn_vld,
    input  logic  dn_rdy,
    output beat_t dn_dat
);

    logic  out_vld_q;
    logic  skid_vld_q;
    logic  rdy_q;
    beat_t out_q;
    beat_t skid_q;

    logic  out_fire;
    logic  up_fire;
    logic  skid_vld_nxt;

    always_comb begin
        out_fire     = out_vld_q && dn_rdy;
        up_fire      = up_vld && rdy_q;
        skid_vld_nxt = skid_vld_q;
        if (skid_vld_q) begin
            if (out_fire) begin
                skid_vld_nxt = 1'b0;
            end
        end else if (up_fire && out_vld_q && !dn_rdy) begin
            skid_vld_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            // Ready is computed a cycle ahead so it never sees dn_rdy combinationally.
            rdy_q      <= !skid_vld_nxt;
            skid_vld_q <= skid_vld_nxt;
            if (skid_vld_q) begin
                // Skid full means up_rdy is low: only the drain path can move.
                if (out_fire) begin
                    out_q <= skid_q;
                end
            end else if (up_fire) begin
                if (!out_vld_q || dn_rdy) begin
                    out_q     <= up_dat;
                    out_vld_q <= 1'b1;
                end else begin
                    skid_q <= up_dat;
                end
            end else if (out_fire) begin
                // Clear the payload so no stale field (e.g. last) lingers without valid.
                out_vld_q <= 1'b0;
                out_q     <= '0;
            end
        end
    end

    assign up_rdy = rdy_q;
    assign dn_vld = out_vld_q;
    assign dn_dat = out_q;

`ifndef SYNTHESIS
    // up_rdy this cycle is fully determined by the previous cycle's state.
    a_rdy_registered: assert property (@(posedge clk)
        $past(rst_n) |-> (up_rdy == !$past(skid_vld_nxt)));
`endif

endmodule

// File: rtl/axis_ingress.sv
// AXI-stream chip-edge ingress: registered skid slice plus max-frame-length policing.
// Latency: one cycle from s acceptance to m presentation; full throughput while m_tready=1.
// Backpressure: s_tready is a flop (skid empty); discarded beats still obey the buffer's ready.
//
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   s_tdata/tvalid/tready/tlast/tuser   external stream in
//   m_tdata/tvalid/tready/tlast/tuser   internal stream out (registered)
//   frame_cnt, trunc_cnt                frames delivered on m, frames truncated (wrapping)
//   in_frame                            high between first and last accepted s beat
module axis_ingress
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int MAX_BEATS  = 256,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    input  logic [USER_WIDTH-1:0] s_tuser,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic [USER_WIDTH-1:0] m_tuser,
    output logic [CNT_WIDTH-1:0]  frame_cnt,
    output logic [CNT_WIDTH-1:0]  trunc_cnt,
    output logic                  in_frame
);

    localparam int               IDX_W    = $clog2(MAX_BEATS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_BEATS - 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
        logic [USER_WIDTH-1:0] user;
    } beat_t;

    ingress_state_e   state;
    logic [IDX_W-1:0] beat_idx;

    logic  accept;
    logic  at_limit;
    logic  truncate;
    logic  wr_vld;
    beat_t wr_dat;
    beat_t rd_dat;

    always_comb begin
        accept   = s_tvalid && s_tready;
        at_limit = (beat_idx == LAST_IDX);
        truncate = accept && (state == ST_PASS) && at_limit && !s_tlast;
        // In DISCARD the beat is consumed by the handshake but never written.
        wr_vld   = s_tvalid && (state == ST_PASS);

        wr_dat.data = s_tdata;
        wr_dat.last = s_tlast;
        wr_dat.user = s_tuser;
        if (at_limit && !s_tlast) begin
            // Last allowed beat of an oversize frame: close it and flag the error.
            wr_dat.last             = 1'b1;
            wr_dat.user[USER_WIDTH-1] = 1'b1;
        end
    end

    axis_skid_buffer #(
        .beat_t (beat_t)
    ) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .up_vld (wr_vld),
        .up_rdy (s_tready),
        .up_dat (wr_dat),
        .dn_vld (m_tvalid),
        .dn_rdy (m_tready),
        .dn_dat (rd_dat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_PASS;
            beat_idx  <= '0;
            in_frame  <= 1'b0;
            frame_cnt <= '0;
            trunc_cnt <= '0;
        end else begin
            if (accept) begin
                in_frame <= !s_tlast;
                if (state == ST_PASS) begin
                    if (s_tlast || at_limit) begin
                        beat_idx <= '0;
                    end else begin
                        beat_idx <= beat_idx + IDX_W'(1);
                    end
                    if (truncate) begin
                        state     <= ST_DISCARD;
                        trunc_cnt <= trunc_cnt + CNT_WIDTH'(1);
                    end
                end else if (s_tlast) begin
                    state <= ST_PASS;
                end
            end
            if (m_tvalid && m_tready && m_tlast) begin
                frame_cnt <= frame_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign m_tdata = rd_dat.data;
    assign m_tlast = rd_dat.last;
    assign m_tuser = rd_dat.user;

`ifndef SYNTHESIS
    a_last_has_valid: assert property (@(posedge clk)
        $past(rst_n) |-> (!m_tlast || m_tvalid));

    a_stall_stable: assert property (@(posedge clk)
        ($past(rst_n) && $past(m_tvalid) && !$past(m_tready))
        |-> (m_tvalid && $stable(m_tdata) && $stable(m_tlast) && $stable(m_tuser)));
`endif

endmodule

// File: tb/tb_axis_ingress.sv
module tb_axis_ingress;

    localparam int DW = 64;
    localparam int UW = 2;
    localparam int MB = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_tlast = 1'b0;
    logic [UW-1:0] s_tuser = '0;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          m_tlast;
    logic [UW-1:0] m_tuser;
    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] trunc_cnt;
    logic          in_frame;

    axis_ingress #(
        .DATA_WIDTH (DW),
        .USER_WIDTH (UW),
        .MAX_BEATS  (MB),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tlast   (s_tlast),
        .s_tuser   (s_tuser),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tlast   (m_tlast),
        .m_tuser   (m_tuser),
        .frame_cnt (frame_cnt),
        .trunc_cnt (trunc_cnt),
        .in_frame  (in_frame)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [UW-1:0] user;
    } beat_t;

    // Reference model state: frame-level view of the stream.
    beat_t exp_q[$];
    int    pos;          // 1-based position of the latest accepted beat in its input frame
    int    m_frames;
    int    m_truncs;
    bit    m_inframe;
    bit    hs_seen;
    bit    prev_stall;
    beat_t prev_beat;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor at negedge: inputs/outputs are stable, and what is seen here is exactly
    // what the next posedge will act on.
    always @(negedge clk) begin
        beat_t e;
        beat_t b;
        hs_seen = 1'b0;
        if (!rst_n) begin
            exp_q.delete();
            pos        = 0;
            m_frames   = 0;
            m_truncs   = 0;
            m_inframe  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("frame_cnt", frame_cnt, m_frames % (1 << CW));
            chk("trunc_cnt", trunc_cnt, m_truncs % (1 << CW));
            chk("in_frame", in_frame, m_inframe);
            b = {m_tdata, m_tlast, m_tuser};
            if (prev_stall) chk("stall_hold", {m_tvalid, b}, {1'b1, prev_beat});
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {1'b1, b}, '0);
                end else begin
                    e = exp_q.pop_front();
                    chk("m_beat", b, e);
                    if (e.last) m_frames++;
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_beat  = b;
            if (s_tvalid && s_tready) begin
                hs_seen = 1'b1;
                pos++;
                if (pos < MB || (pos == MB && s_tlast)) begin
                    exp_q.push_back({s_tdata, s_tlast, s_tuser});
                end else if (pos == MB) begin
                    exp_q.push_back({s_tdata, 1'b1, s_tuser | UW'(1 << (UW - 1))});
                    m_truncs++;
                end
                if (s_tlast) pos = 0;
                m_inframe = !s_tlast;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 m_tready=1, 1 toggle, 2 random, 3 held low
    task automatic send(input logic [DW-1:0] d, input logic last, input logic [UW-1:0] u,
                        input int mode, output int waited);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        s_tuser  = u;
        waited   = 0;
        for (int c = 0; c < 40; c++) begin
            case (mode)
                1:       m_tready = !m_tready;
                2:       m_tready = 1'($urandom_range(0, 1));
                3:       m_tready = 1'b0;
                default: m_tready = 1'b1;
            endcase
            tick();
            if (hs_seen) begin
                s_tvalid = 1'b0;
                return;
            end
            waited++;
        end
        chk("send_timeout", 1'b1, 1'b0);
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (exp_q.size() == 0 && !m_tvalid) break;
        end
        chk("drain_empty", {exp_q.size() != 0, m_tvalid}, '0);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    typedef struct {
        logic          v;
        logic          last;
        logic [DW-1:0] d;
        logic          mr;
        logic          e_srdy;
        logic          e_mv;
        logic          e_ml;
        logic [DW-1:0] e_md;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int w;
        int len;

        tbl[0] = '{1'b1, 1'b0, 64'hA0, 1'b1, 1'b1, 1'b1, 1'b0, 64'hA0};
        tbl[1] = '{1'b1, 1'b0, 64'hA1, 1'b1, 1'b1, 1'b1, 1'b0, 64'hA1};
        tbl[2] = '{1'b1, 1'b0, 64'hA2, 1'b1, 1'b1, 1'b1, 1'b0, 64'hA2};
        tbl[3] = '{1'b1, 1'b1, 64'hA3, 1'b1, 1'b1, 1'b1, 1'b1, 64'hA3};
        tbl[4] = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 1'b0, 64'h0};
        tbl[5] = '{1'b1, 1'b0, 64'hB0, 1'b0, 1'b1, 1'b1, 1'b0, 64'hB0};
        tbl[6] = '{1'b1, 1'b1, 64'hB1, 1'b0, 1'b0, 1'b1, 1'b0, 64'hB0};
        tbl[7] = '{1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 1'b1, 1'b0, 64'hB0};
        tbl[8] = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 1'b1, 64'hB1};
        tbl[9] = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 1'b0, 64'h0};

        // Reset behaviour and release.
        tick();
        tick();
        chk("rst_s_tready", s_tready, 1'b0);
        chk("rst_m_tvalid", m_tvalid, 1'b0);
        chk("rst_m_payload", {m_tdata, m_tlast, m_tuser}, '0);
        chk("rst_counters", {frame_cnt, trunc_cnt, in_frame}, '0);
        rst_n = 1'b1;
        tick();
        chk("rel_s_tready", s_tready, 1'b1);
        chk("rel_m_tvalid", m_tvalid, 1'b0);
        tick();
        chk("idle_m_tvalid", m_tvalid, 1'b0);

        // Cycle-exact vectors: back-to-back frame, then a stall that fills the skid.
        for (int i = 0; i < 10; i++) begin
            s_tvalid = tbl[i].v;
            s_tlast  = tbl[i].last;
            s_tdata  = tbl[i].d;
            s_tuser  = '0;
            m_tready = tbl[i].mr;
            tick();
            chk($sformatf("vec%0d_s_tready", i), s_tready, tbl[i].e_srdy);
            chk($sformatf("vec%0d_m_tvalid", i), m_tvalid, tbl[i].e_mv);
            if (tbl[i].e_mv) begin
                chk($sformatf("vec%0d_m_tlast", i), m_tlast, tbl[i].e_ml);
                chk($sformatf("vec%0d_m_tdata", i), m_tdata, tbl[i].e_md);
            end
        end
        chk("vec_frame_cnt", frame_cnt, 4'd2);

        // 10-beat frame with m_tready toggling every cycle.
        for (int i = 0; i < 10; i++) begin
            send(64'hC00 + 64'(i), i == 9, 2'(i), 1, w);
            chk("toggle_s_rdy_low", w > 1, 1'b0);
        end
        drain();
        chk("toggle_frame_cnt", frame_cnt, 4'd3);

        // Exactly MAX_BEATS frame, oversize frame, then a clean short frame.
        do_reset();
        for (int i = 0; i < 4; i++) send(64'hD00 + 64'(i), i == 3, 2'b00, 0, w);
        drain();
        chk("full_len_trunc", trunc_cnt, 4'd0);
        chk("full_len_frames", frame_cnt, 4'd1);
        for (int i = 0; i < 7; i++) send(64'hE00 + 64'(i), i == 6, 2'b01, 0, w);
        drain();
        chk("over_trunc", trunc_cnt, 4'd1);
        chk("over_frames", frame_cnt, 4'd2);
        chk("over_in_frame", in_frame, 1'b0);
        for (int i = 0; i < 2; i++) send(64'hF00 + 64'(i), i == 1, 2'b00, 0, w);
        drain();
        chk("after_over_frames", frame_cnt, 4'd3);
        chk("after_over_trunc", trunc_cnt, 4'd1);

        // Reset mid-frame with output and skid both full.
        send(64'h100, 1'b0, 2'b00, 3, w);
        send(64'h101, 1'b0, 2'b00, 3, w);
        tick();
        chk("skid_full_s_rdy", s_tready, 1'b0);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_m_tvalid", m_tvalid, 1'b0);
        chk("mid_rst_s_tready", s_tready, 1'b0);
        chk("mid_rst_counters", {frame_cnt, trunc_cnt, in_frame}, '0);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) send(64'h200 + 64'(i), i == 1, 2'b10, 0, w);
        drain();
        chk("post_rst_frames", frame_cnt, 4'd1);

        // Randomized frames against the reference model.
        for (int f = 0; f < 300; f++) begin
            len = $urandom_range(1, 7);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    s_tvalid = 1'b0;
                    m_tready = 1'($urandom_range(0, 1));
                    tick();
                end
                send({$urandom, $urandom}, i == len - 1, 2'($urandom_range(0, 3)), 2, w);
            end
        end
        drain();
        chk("rand_in_frame", in_frame, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/axis_ingress.md
# axis_ingress

AXI stream ingress boundary: accepts beats from the external stream and presents them on the internal stream through a registered two-entry skid buffer. It breaks the ready and valid timing paths at the chip edge and enforces a maximum frame length. Oversize frames are truncated with an error flag in tuser, and their excess beats are discarded. It sits at the input of the datapath, the mirror of the egress shim at the output.

## Interface
- DATA_WIDTH, 64, beat data width in bits
- USER_WIDTH, 1, sideband width; bit USER_WIDTH-1 doubles as the truncation error flag
- MAX_BEATS, 256, maximum beats per frame, ≥ 2
- CNT_WIDTH, 32, width of the statistics counters
- clk  in  1  sole clock
- rst_n  in  1  reset, synchronous, active-low; one clock, reset is synchronous and active-low
- s_tdata  in  DATA_WIDTH  external beat data
- s_tvalid  in  1  external valid
- s_tready  out  1  external ready, driven straight from a flop
- s_tlast  in  1  external end of frame
- s_tuser  in  USER_WIDTH  external sideband
- m_tdata  out  DATA_WIDTH  internal beat data, registered
- m_tvalid  out  1  internal valid, registered
- m_tready  in  1  internal ready
- m_tlast  out  1  internal end of frame, registered
- m_tuser  out  USER_WIDTH  internal sideband, registered
- frame_cnt  out  CNT_WIDTH  count of frames delivered on m (handshake with m_tlast)
- trunc_cnt  out  CNT_WIDTH  count of frames truncated
- in_frame  out  1  high between the first and last accepted s beat of a frame

## Operation
- Skid buffer: an output register plus one skid register.
  - s_tready = !skid_valid, registered.
  - When m is stalled and the output register is full, an accepted beat goes to the skid register.
  - The skid register drains into the output register on the next m handshake.
- Beat counter beat_idx, width $clog2(MAX_BEATS). It counts accepted s beats of the current frame.
  - Clears on an accepted s_tlast.
  - Clears on the forced-last beat.
- FSM states:
  - PASS:
    - Accepted beats enter the buffer unchanged.
    - If beat_idx == MAX_BEATS-1 and s_tlast = 0, the beat is forwarded with tlast forced to 1 and tuser[USER_WIDTH-1] forced to 1.
    - trunc_cnt increments, and the FSM moves to DISCARD.
  - DISCARD:
    - Beats are accepted, with s_tready following normal buffer rules, but they are not written to the buffer.
    - An accepted beat with s_tlast returns the FSM to PASS.
- A beat with s_tlast at beat_idx == MAX_BEATS-1 is a legal full-length frame: no flag, no truncation.
- Counters increment by 1 and wrap modulo 2^CNT_WIDTH.
- in_frame sets on an accepted beat without tlast. It clears on an accepted beat with tlast, including discarded ones.
- The block never reorders, duplicates or drops beats outside DISCARD. tdata, tlast and tuser stay stable while m_tvalid=1 and m_tready=0.

## Timing
- Reset (rst_n=0 at a clk edge):
  - s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0, m_tuser=0.
  - frame_cnt=0, trunc_cnt=0, in_frame=0, state PASS, beat_idx=0, skid empty.
- s_tready becomes 1 on the first edge with rst_n=1.
- Latency: an s beat accepted at edge N is visible on m after edge N, i.e. one cycle.
- Throughput: one beat per cycle while m_tready=1.
- m_tready low for one cycle: at most one extra beat is absorbed. s_tready drops the cycle after the skid fills and rises the cycle after it drains.
- Simultaneous m handshake and s acceptance with the skid empty: the output register reloads directly and the skid is not used.
- Reset mid-frame: all buffered beats are dropped, no partial tlast is emitted, and the FSM restarts in PASS.
- frame_cnt updates on the edge of the m_tlast handshake.
- trunc_cnt updates on the edge at which the truncating s beat is accepted.

## Structure
- Shared package axis_pkg holds:
  - the typedef enum ingress_state_e {ST_PASS, ST_DISCARD};
  - a packed struct axis_beat_t {data, last, user}, parameterised through the package default widths.
- Sub-module axis_skid_buffer, a generic 2-entry register slice over axis_beat_t. It is reusable by other blocks.
- axis_ingress wraps axis_skid_buffer with the FSM, beat counter and statistics.
- Non-synthesis assertions:
  - m payload is stable under backpressure;
  - m_tlast implies m_tvalid;
  - s_tready has no combinational path from m_tready.

## Test plan
- Back-to-back 4-beat frame, m_tready=1 → 4 beats out, each one cycle after input, m_tlast on beat 4, frame_cnt=1, s_tready constant 1.
- m_tready toggled 1/0 every cycle during a 10-beat frame → all 10 beats in order, payload stable when stalled, s_tready low at most one cycle per stall.
- MAX_BEATS=4, 7-beat frame → 4 beats out, beat 4 has tlast=1 and tuser MSB=1. Beats 5–7 are accepted but absent on m. trunc_cnt=1, frame_cnt=1, and the next frame passes cleanly.
- MAX_BEATS=4, exactly 4-beat frame → no flag, trunc_cnt=0.
- rst_n low for 1 cycle mid-frame with the skid full → next cycle m_tvalid=0, s_tready=0, counters 0. A following 2-beat frame is delivered intact.
- Reset release → s_tready=0 during reset and 1 one cycle after release. m_tvalid stays 0 until the first s beat.
